// File: rtl/anycore_l15_reqdecoder.sv
// Funnels AnyCore icache-miss, dcache-load-miss and store requests into a single
// L1.5 request port, one request in flight at a time, round-robin IC -> LD -> ST.
module anycore_l15_reqdecoder #(
    parameter int         PADDR_W        = 40,
    parameter logic [2:0] LINE_SIZE_CODE = 3'b111
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               anycore_ic2mem_reqvalid,
    input  logic [PADDR_W-1:0] anycore_ic2mem_reqaddr,
    input  logic               anycore_dc2mem_ldvalid,
    input  logic [PADDR_W-1:0] anycore_dc2mem_ldaddr,
    input  logic               anycore_dc2mem_stvalid,
    input  logic [PADDR_W-1:0] anycore_dc2mem_staddr,
    input  logic [63:0]        anycore_dc2mem_stdata,
    input  logic [1:0]         anycore_dc2mem_stsize,
    output logic               transducer_l15_val,
    output logic [4:0]         transducer_l15_rqtype,
    output logic [2:0]         transducer_l15_size,
    output logic [PADDR_W-1:0] transducer_l15_address,
    output logic [63:0]        transducer_l15_data,
    output logic               transducer_l15_nc,
    output logic               transducer_l15_threadid,
    input  logic               l15_transducer_ack,
    output logic               anycoredecoder_overflow
);
    // Handshake: while val is high every request field is held stable; the
    // request completes on the rising edge where ack is sampled high.
    localparam logic [4:0] LOAD_RQ  = 5'b00000;
    localparam logic [4:0] STORE_RQ = 5'b00001;
    localparam logic [4:0] IMISS_RQ = 5'b10000;

    localparam logic [1:0] CL_IC = 2'd0;
    localparam logic [1:0] CL_LD = 2'd1;
    localparam logic [1:0] CL_ST = 2'd2;

    typedef enum logic {IDLE, REQ} state_t;

    state_t             state, state_nxt;
    logic               ic_pend, ld_pend, st_pend;
    logic [PADDR_W-1:0] ic_addr, ld_addr, st_addr;
    logic [63:0]        st_data;
    logic [1:0]         st_size;
    logic [1:0]         rr, sel, pick;
    logic               any_pend, grant, fire;
    logic               ic_clr, ld_clr, st_clr;
    logic [4:0]         rqtype_q;
    logic [2:0]         size_q;
    logic [PADDR_W-1:0] addr_q;
    logic [63:0]        data_q;

    // L1.5 expects big-endian store data: byte 0 lands in bits [63:56].
    function automatic logic [63:0] swap_bytes(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*(7-i) +: 8] = d[8*i +: 8];
        return r;
    endfunction

    assign any_pend = ic_pend | ld_pend | st_pend;
    assign fire     = (state == REQ) && l15_transducer_ack;
    assign ic_clr   = fire && (sel == CL_IC);
    assign ld_clr   = fire && (sel == CL_LD);
    assign st_clr   = fire && (sel == CL_ST);

    always_comb begin
        pick = CL_IC;
        case (rr)
            CL_LD:   pick = ld_pend ? CL_LD : (st_pend ? CL_ST : CL_IC);
            CL_ST:   pick = st_pend ? CL_ST : (ic_pend ? CL_IC : CL_LD);
            default: pick = ic_pend ? CL_IC : (ld_pend ? CL_LD : CL_ST);
        endcase
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: if (any_pend) begin
                state_nxt = REQ;
                grant     = 1'b1;
            end
            REQ:  if (l15_transducer_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A buffer being released by this cycle's ack is free to refill at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            ic_pend                 <= 1'b0;
            ld_pend                 <= 1'b0;
            st_pend                 <= 1'b0;
            anycoredecoder_overflow <= 1'b0;
        end else begin
            if (anycore_ic2mem_reqvalid && (!ic_pend || ic_clr)) begin
                ic_pend <= 1'b1;
                ic_addr <= {anycore_ic2mem_reqaddr[PADDR_W-1:5], 5'b0};
            end else if (ic_clr) begin
                ic_pend <= 1'b0;
            end
            if (anycore_dc2mem_ldvalid && (!ld_pend || ld_clr)) begin
                ld_pend <= 1'b1;
                ld_addr <= {anycore_dc2mem_ldaddr[PADDR_W-1:4], 4'b0};
            end else if (ld_clr) begin
                ld_pend <= 1'b0;
            end
            if (anycore_dc2mem_stvalid && (!st_pend || st_clr)) begin
                st_pend <= 1'b1;
                st_addr <= anycore_dc2mem_staddr;
                st_data <= anycore_dc2mem_stdata;
                st_size <= anycore_dc2mem_stsize;
            end else if (st_clr) begin
                st_pend <= 1'b0;
            end
            if ((anycore_ic2mem_reqvalid && ic_pend && !ic_clr) ||
                (anycore_dc2mem_ldvalid  && ld_pend && !ld_clr) ||
                (anycore_dc2mem_stvalid  && st_pend && !st_clr))
                anycoredecoder_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr       <= CL_IC;
            sel      <= CL_IC;
            rqtype_q <= '0;
            size_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else if (grant) begin
            sel <= pick;
            case (pick)
                CL_IC: begin
                    rqtype_q <= IMISS_RQ;
                    size_q   <= LINE_SIZE_CODE;
                    addr_q   <= ic_addr;
                    data_q   <= '0;
                end
                CL_LD: begin
                    rqtype_q <= LOAD_RQ;
                    size_q   <= LINE_SIZE_CODE;
                    addr_q   <= ld_addr;
                    data_q   <= '0;
                end
                default: begin
                    rqtype_q <= STORE_RQ;
                    size_q   <= {1'b0, st_size};
                    addr_q   <= st_addr;
                    data_q   <= swap_bytes(st_data);
                end
            endcase
        end else if (fire) begin
            rr       <= (sel == CL_ST) ? CL_IC : sel + 2'd1;
            rqtype_q <= '0;
            size_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end
    end

    assign transducer_l15_val      = (state == REQ);
    assign transducer_l15_rqtype   = rqtype_q;
    assign transducer_l15_size     = size_q;
    assign transducer_l15_address  = addr_q;
    assign transducer_l15_data     = data_q;
    assign transducer_l15_nc       = 1'b0;
    assign transducer_l15_threadid = 1'b0;

endmodule
